// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges the cache's single 256-bit line transfer to a
// 64-bit burst memory port. Write-backs are serialised beat by beat from a
// latched copy of the line; fills are assembled beat by beat into line_o.
// Optional watchdog: define CACHELINE_ADAPTOR_TIMEOUT_EN to abort a burst that
// sees TIMEOUT_CYCLES consecutive cycles without a memory strobe.
module cacheline_adaptor #(
  parameter int LINE_WIDTH     = 256,
  parameter int BURST_WIDTH    = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LINE_WIDTH-1:0] line_i,
  output logic [LINE_WIDTH-1:0] line_o,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic                  read_i,
  input  logic                  write_i,
  output logic                  resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0] address_o,
  output logic                  read_o,
  output logic                  write_o,
  input  logic                  resp_i,
  output logic                  error_o
);

  localparam int BEATS    = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFSET_W = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  // Clears the byte-within-line offset so memory always sees a line-aligned address.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << OFFSET_W) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [LINE_WIDTH-1:0]  wline_q, wline_d;
  logic [LINE_WIDTH-1:0]  line_q, line_d;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             err_q, err_d;
`endif

  // Next-state, beat counter, latched request and fill assembly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    line_d  = line_q;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    tmr_d   = '0;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Write-back wins when both requests are raised together.
        if (write_i) begin
          wline_d = line_i;
          addr_d  = address_i & ALIGN_MASK;
          state_d = WRITE;
        end else if (read_i) begin
          addr_d  = address_i & ALIGN_MASK;
          state_d = READ;
        end
      end
      READ: begin
        if (resp_i) begin
          line_d[int'(cnt_q) * BURST_WIDTH +: BURST_WIDTH] = burst_i;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        if (resp_i) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        // Requests are still held high here; they are not re-accepted.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    // Watchdog: only strobe-free cycles inside a burst count toward the limit.
    if (state_q == READ || state_q == WRITE) begin
      if (resp_i) begin
        tmr_d = '0;
      end else if (tmr_q == TMR_LAST) begin
        state_d = DONE;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end
`endif
  end

  // State and datapath registers; reset also clears any partially filled line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      line_q  <= '0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
      tmr_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      line_q  <= line_d;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
      tmr_q   <= tmr_d;
      err_q   <= err_d;
`endif
    end
  end

  // Handshake outputs decode registered state only, so no cache input reaches them.
  assign read_o    = (state_q == READ);
  assign write_o   = (state_q == WRITE);
  assign resp_o    = (state_q == DONE);
  assign address_o = addr_q;
  assign line_o    = line_q;
  assign burst_o   = (state_q == WRITE) ?
                     wline_q[int'(cnt_q) * BURST_WIDTH +: BURST_WIDTH] : '0;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  assign error_o = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign error_o = 1'b0;
`endif

endmodule
